// File: rtl/idli_sqi_pkg.sv
// Shared types and constants for the idli SQI responder.
// Holds the FSM state encoding, command opcodes and the nibble-counter width.
package idli_sqi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StRdata,
    StWdata,
    StIgnore
  } sqi_state_e;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  // Wide enough for up to 16 address or dummy nibbles.
  localparam int unsigned NibCntW = 4;
  typedef logic [NibCntW-1:0] nib_cnt_t;

endpackage

// File: rtl/idli_sqi_sync.sv
// Two-flop synchronizer and edge detector for the SQI pins.
// Data is delayed by the same two flops so it lines up with the sck edge pulses.
module idli_sqi_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs,
  input  logic [3:0] din,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] dsync
);

  logic       sck_m_q, sck_s_q, sck_p_q;
  logic       cs_m_q, cs_s_q, cs_p_q;
  logic [3:0] din_m_q, din_s_q;
  logic [1:0] prime_q;
  logic       armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_m_q <= 1'b0;
      sck_s_q <= 1'b0;
      sck_p_q <= 1'b0;
      cs_m_q  <= 1'b1;
      cs_s_q  <= 1'b1;
      cs_p_q  <= 1'b1;
      din_m_q <= '0;
      din_s_q <= '0;
      prime_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sck_m_q <= sck;
      sck_s_q <= sck_m_q;
      sck_p_q <= sck_s_q;
      cs_m_q  <= cs;
      cs_s_q  <= cs_m_q;
      cs_p_q  <= cs_s_q;
      din_m_q <= din;
      din_s_q <= din_m_q;
      prime_q <= {prime_q[0], 1'b1};
      // Only a CS high actually sampled from the pin (not the reset value) arms cs_fall,
      // so a reset with CS held low stays deaf until CS toggles high then low.
      if (prime_q[1] && cs_s_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sck_rise = sck_s_q & ~sck_p_q;
  assign sck_fall = ~sck_s_q & sck_p_q;
  assign cs_rise  = cs_s_q & ~cs_p_q;
  assign cs_fall  = armed_q & ~cs_s_q & cs_p_q;
  assign dsync    = din_s_q;

endmodule

// File: rtl/idli_sqi_resp.sv
// SQI responder: decodes READ/WRITE commands from an oversampled quad-SPI bus and
// streams bytes to/from a byte-wide local memory port.
module idli_sqi_resp
  import idli_sqi_pkg::*;
#(
  parameter int unsigned ADDR_NIBBLES  = 6,
  parameter int unsigned DUMMY_NIBBLES = 2,
  localparam int unsigned ADDR_W       = 4 * ADDR_NIBBLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sqi_sck_i,
  input  logic              sqi_cs_i,
  input  logic [3:0]        sqi_data_i,
  output logic [3:0]        sqi_data_o,
  output logic              sqi_data_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err
);

  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic [3:0] dsync;

  idli_sqi_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sqi_sck_i),
    .cs       (sqi_cs_i),
    .din      (sqi_data_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .dsync    (dsync)
  );

  sqi_state_e        state_q, state_d;
  nib_cnt_t          cnt_q, cnt_d;
  logic [3:0]        cmd_hi_q, cmd_hi_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rbyte_q, rbyte_d;
  logic [3:0]        lo_q, lo_d;
  logic              hi_q, hi_d;
  logic [3:0]        wbuf_q, wbuf_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              re_dly_q;
  logic              err_q, err_d;
  logic [7:0]        cmd_byte;

  assign cmd_byte = {cmd_hi_q, dsync};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_hi_d  = cmd_hi_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    rbyte_d   = rbyte_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    wbuf_d    = wbuf_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    err_d     = 1'b0;

    // Read data lands one clk after the strobe; the write address advances after its strobe.
    if (re_dly_q) begin
      rbyte_d = mem_rdata;
    end
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (cs_rise) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      dout_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            cmd_hi_d = dsync;
            cnt_d    = cnt_q + nib_cnt_t'(1);
            if (cnt_q != '0) begin
              cnt_d = '0;
              if (cmd_byte == SQI_CMD_READ) begin
                state_d   = StAddr;
                is_read_d = 1'b1;
              end else if (cmd_byte == SQI_CMD_WRITE) begin
                state_d   = StAddr;
                is_read_d = 1'b0;
              end else begin
                state_d = StIgnore;
                err_d   = 1'b1;
              end
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            addr_d = ADDR_W'({addr_q, dsync});
            cnt_d  = cnt_q + nib_cnt_t'(1);
            if (cnt_q == nib_cnt_t'(ADDR_NIBBLES - 1)) begin
              cnt_d = '0;
              hi_d  = 1'b1;
              if (is_read_q) begin
                re_d    = 1'b1;
                state_d = (DUMMY_NIBBLES == 0) ? StRdata : StDummy;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StDummy: begin
          if (sck_rise) begin
            cnt_d = cnt_q + nib_cnt_t'(1);
            if (cnt_q == nib_cnt_t'(DUMMY_NIBBLES - 1)) begin
              cnt_d   = '0;
              state_d = StRdata;
            end
          end
        end
        StRdata: begin
          if (sck_fall) begin
            oe_d = 1'b1;
            if (hi_q) begin
              // Keep the low nibble aside so the prefetch can overwrite rbyte.
              dout_d = rbyte_q[7:4];
              lo_d   = rbyte_q[3:0];
              addr_d = addr_q + ADDR_W'(1);
              re_d   = 1'b1;
              hi_d   = 1'b0;
            end else begin
              dout_d = lo_q;
              hi_d   = 1'b1;
            end
          end
        end
        StWdata: begin
          if (sck_rise) begin
            if (hi_q) begin
              wbuf_d = dsync;
              hi_d   = 1'b0;
            end else begin
              wdata_d = {wbuf_q, dsync};
              we_d    = 1'b1;
              hi_d    = 1'b1;
            end
          end
        end
        StIgnore: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_hi_q  <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      rbyte_q   <= '0;
      lo_q      <= '0;
      hi_q      <= 1'b1;
      wbuf_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      re_dly_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_hi_q  <= cmd_hi_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      rbyte_q   <= rbyte_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      wbuf_q    <= wbuf_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      re_q      <= re_d;
      re_dly_q  <= re_q;
      err_q     <= err_d;
    end
  end

  assign sqi_data_o  = dout_q;
  assign sqi_data_oe = oe_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = we_q;
  assign mem_re      = re_q;
  assign busy        = (state_q != StIdle);
  assign err         = err_q;

endmodule

// File: doc/idli_sqi_resp.md
Name: idli_sqi_resp

Overview:
- Synthesizable SQI (quad-SPI) responder: the target end of the serial-memory link the idli core drives (SCK, active-low CS, 4-bit data).
- Oversamples the master's SCK/CS/data on the local clock, decodes READ/WRITE commands, and streams bytes to and from a byte-wide local memory port.
- Used as an on-chip memory target for loopback and bring-up, and as the reference responder for the core's SQI initiator.

Parameters:
ADDR_NIBBLES, 6, address nibbles after the command; ADDR_W = 4*ADDR_NIBBLES
DUMMY_NIBBLES, 2, turnaround nibbles between address and read data

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
sqi_sck_i  in  1  master serial clock, asynchronous; must be <= clk/4
sqi_cs_i  in  1  master chip select, active low, asynchronous
sqi_data_i  in  4  master data nibble
sqi_data_o  out  4  responder data nibble
sqi_data_oe  out  1  output enable for sqi_data_o
mem_addr  out  ADDR_W  local memory byte address
mem_wdata  out  8  local write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe; mem_rdata valid exactly 1 clk later
mem_rdata  in  8  local read data
busy  out  1  high while a transaction is in progress (state != IDLE)
err  out  1  one-cycle pulse on an unsupported command

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE; sqi_data_o=0, sqi_data_oe=0, mem_we=0, mem_re=0, busy=0, err=0, mem_addr=0, mem_wdata=0.
- Reset also sets the synchronizer CS flops to 1 and the SCK flops to 0.
- Synchronization:
  - sck, cs and data each pass through 2 flops.
  - rise = sck_s & ~sck_q; fall = ~sck_s & sck_q.
  - cs_fall / cs_rise are detected the same way.
  - All sampling uses the synchronized data aligned with rise.
- Nibble order: MSB nibble first for command, address and data.
- State machine:
  - IDLE: on cs_fall go to CMD with nibble count 0. Any other SCK activity is ignored.
  - CMD: sample 2 nibbles on rise.
    - Command 0x03 -> ADDR (read).
    - Command 0x02 -> ADDR (write).
    - Any other command -> IGNORE, with err pulsing for 1 clk.
  - ADDR: shift in ADDR_NIBBLES nibbles on rise into mem_addr.
    - Read: mem_re pulses on the clk after the last address nibble; go to DUMMY. If DUMMY_NIBBLES=0, go straight to RDATA.
    - Write: go to WDATA.
  - DUMMY: count DUMMY_NIBBLES rises, then go to RDATA. The byte from mem_rdata is latched into the shift register the clk after mem_re.
  - RDATA: on each fall, sqi_data_oe=1 and sqi_data_o takes the next nibble.
    - High nibble: also increment mem_addr (wraps to 0 at 2^ADDR_W) and pulse mem_re to prefetch the next byte.
    - Low nibble: load the prefetched byte for the next fall.
  - WDATA: on rise, capture the high nibble, then the low nibble.
    - After the low nibble: mem_wdata=byte, mem_we=1 for 1 clk with the current mem_addr; on the following clk mem_addr increments with wrap.
  - IGNORE: no outputs driven; wait for CS.
- CS deassert: cs_rise in any state returns to IDLE on the next clk with sqi_data_oe=0.
  - A partially received write byte is discarded (no mem_we).
  - A partial address or command is discarded.
- Same-cycle cs_rise with rise or fall: cs_rise wins. The nibble is not consumed and not driven.
- Read and write strobes never overlap. mem_re and mem_we are never both high.
- Reset mid-transaction:
  - The responder returns to IDLE.
  - If CS is still low after reset, it ignores the bus until CS goes high then low again. The CS sync flops reset to 1, so no cs_fall is seen.
- busy rises the clk after cs_fall and falls with the return to IDLE.

Decomposition:
- Package idli_sqi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE);
  - command constants SQI_CMD_READ=8'h03 and SQI_CMD_WRITE=8'h02;
  - nibble-count widths.
- Sub-module idli_sqi_sync: 2-flop synchronizer plus edge detect for sck/cs, with data passthrough aligned to the edge outputs.

Test Plan:
- Write: CS low, nibbles 0,2 | 00,00,10 | A,5,3,C, CS high -> mem_we twice: addr 0x000010 data 0xA5, then addr 0x000011 data 0x3C.
- Read: preload mem[0x20]=0x12, mem[0x21]=0x34. Send cmd 03, addr 0x000020, 2 dummy nibbles, 4 SCKs -> sqi_data_o nibbles 1,2,3,4; oe high from the first data fall until CS rise.
- Address wrap: write 2 bytes starting at 0xFFFFFF -> second mem_we at addr 0x000000.
- Abort: write cmd plus address, then 1 data nibble, then CS high -> no mem_we; busy=0 and oe=0 within 4 clk of CS rising on the pin.
- Bad command 0x9F -> err pulses once, no mem strobes, oe stays 0; the next valid read succeeds.
- Reset during RDATA with CS held low -> oe=0 and busy=0 after reset. SCK toggles are ignored until a fresh CS high->low, after which a read works.
